// File: rtl/poly_pkg.sv
// Shared definitions for the streaming polynomial reducer: mode and state
// encodings plus the add/subtract reduction primitive.
package poly_pkg;

  localparam logic MODE_CYCLIC     = 1'b0;
  localparam logic MODE_NEGACYCLIC = 1'b1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  localparam int RED_MAX_W = 64;

  // Operates at a fixed wide width; callers truncate to their coefficient width,
  // which gives the required modulo-2^WIDTH wrap.
  function automatic logic [RED_MAX_W-1:0] poly_red_op(input logic [RED_MAX_W-1:0] a,
                                                       input logic [RED_MAX_W-1:0] b,
                                                       input logic                 mode);
    return (mode == MODE_NEGACYCLIC) ? (a - b) : (a + b);
  endfunction

endpackage

// File: rtl/poly_coef_buffer.sv
// 2N-entry coefficient register file with indexed write, synchronous clear,
// and paired reads of entries idx and idx+N.
module poly_coef_buffer
  import poly_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 4,
  parameter int CNT_W  = $clog2(2*DEGREE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [CNT_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_lo,
  output logic [WIDTH-1:0] rd_hi
);

  logic [WIDTH-1:0] mem [2*DEGREE];
  logic [CNT_W-1:0] hi_idx;

  assign hi_idx = rd_idx + CNT_W'(DEGREE);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < 2*DEGREE; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write-through so the final input beat can feed r[0] on the same edge it is stored.
  assign rd_lo = (wr_en && (wr_addr == rd_idx)) ? wr_data : mem[rd_idx];
  assign rd_hi = (wr_en && (wr_addr == hi_idx)) ? wr_data : mem[hi_idx];

endmodule

// File: rtl/poly_reduce_stream.sv
// Streams in up to 2N product coefficients, reduces them modulo x^N+1 or x^N-1,
// and streams out the N reduced coefficients with valid/ready on both sides.
module poly_reduce_stream
  import poly_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 4,
  parameter int CNT_W  = $clog2(2*DEGREE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2*DEGREE - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEGREE - 1);
  localparam logic [CNT_W-1:0] PENULT   = CNT_W'(DEGREE - 2);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, idx, rd_idx;
  logic             mode_q, eff_mode;
  logic             in_fire, out_fire, buf_clear;
  logic [WIDTH-1:0] rd_lo, rd_hi, red;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  poly_coef_buffer #(.WIDTH(WIDTH), .DEGREE(DEGREE), .CNT_W(CNT_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clear   (buf_clear),
    .wr_en   (in_fire),
    .wr_addr (cnt),
    .wr_data (in_data),
    .rd_idx  (rd_idx),
    .rd_lo   (rd_lo),
    .rd_hi   (rd_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_next;
  end

  // A single-beat polynomial finishes on its first beat, before mode_q is loaded.
  always_comb begin
    state_next = state;
    buf_clear  = 1'b0;
    rd_idx     = '0;
    eff_mode   = mode_q;
    case (state)
      ST_LOAD: begin
        if (cnt == '0) eff_mode = mode;
        if (in_fire && (in_last || (cnt == LAST_CNT))) state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (idx != LAST_IDX) rd_idx = idx + CNT_W'(1);
        if (out_fire && out_last) begin
          state_next = ST_LOAD;
          buf_clear  = 1'b1;
        end
      end
      default: state_next = ST_LOAD;
    endcase
    red = WIDTH'(poly_red_op(RED_MAX_W'(rd_lo), RED_MAX_W'(rd_hi), eff_mode));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      mode_q    <= MODE_CYCLIC;
    end else begin
      in_ready <= (state_next == ST_LOAD);
      case (state)
        ST_LOAD: begin
          if (in_fire) begin
            cnt  <= cnt + CNT_W'(1);
            busy <= 1'b1;
            if (cnt == '0) mode_q <= mode;
            if (state_next == ST_EMIT) begin
              out_valid <= 1'b1;
              out_data  <= red;
              idx       <= '0;
              out_last  <= (DEGREE == 1);
            end
          end
        end
        ST_EMIT: begin
          if (out_fire) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              cnt       <= '0;
            end else begin
              idx      <= idx + CNT_W'(1);
              out_data <= red;
              out_last <= (idx == PENULT);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
